// File: rtl/id_ex_control_pipe_pkg.sv
// Package for the ID-stage main control and its EX/MEM/WB control pipeline.
// Holds the opcode and func encodings, the aluOp codes and the bubble func, plus
// the per-stage control bundles and their helper functions.
// Optional feature macro: BNE_EN adds the bne decode and the branch_ne field.
package id_ex_control_pipe_pkg;

    localparam int unsigned OPCODE_BITS = 6;
    localparam int unsigned FUNC_BITS   = 6;
    localparam int unsigned ALUOP_BITS  = 2;

    // Opcodes (instr[31:26])
    localparam logic [OPCODE_BITS-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_BITS-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_BITS-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_BITS-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_BITS-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_BITS-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_BITS-1:0] OP_BNE   = 6'b000101;

    // R-type func codes (instr[5:0])
    localparam logic [FUNC_BITS-1:0] FUNC_ADD = 6'b100000;
    localparam logic [FUNC_BITS-1:0] FUNC_SUB = 6'b100010;
    localparam logic [FUNC_BITS-1:0] FUNC_AND = 6'b100100;
    localparam logic [FUNC_BITS-1:0] FUNC_NOR = 6'b100111;
    localparam logic [FUNC_BITS-1:0] FUNC_OR  = 6'b100101;
    localparam logic [FUNC_BITS-1:0] FUNC_SLT = 6'b101010;
    localparam logic [FUNC_BITS-1:0] FUNC_NOP = 6'b000000;

    // A bubble still hands the ALU decoder a well-defined ADD.
    localparam logic [FUNC_BITS-1:0] FUNC_BUBBLE = FUNC_ADD;

    // 2'b11 is reserved and never driven.
    typedef enum logic [ALUOP_BITS-1:0] {
        AluOpFunc = 2'b00,
        AluOpAdd  = 2'b01,
        AluOpSub  = 2'b10
    } alu_op_e;

    // Full control bundle held in the EX stage.
    typedef struct packed {
        alu_op_e              alu_op;
        logic [FUNC_BITS-1:0] func;
        logic                 reg_dst;
        logic                 alu_src;
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch;
`ifdef BNE_EN
        logic                 branch_ne;
`endif
        logic                 reg_write;
        logic                 mem_to_reg;
    } ex_ctrl_t;

    // Controls still needed once the instruction has left EX.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
`ifdef BNE_EN
        logic branch_ne;
`endif
        logic reg_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    function automatic ex_ctrl_t bubble_ctrl();
        ex_ctrl_t c;
        c      = '0;
        c.func = FUNC_BUBBLE;
        return c;
    endfunction

    function automatic mem_ctrl_t to_mem(input ex_ctrl_t e);
        mem_ctrl_t m;
        m.mem_read   = e.mem_read;
        m.mem_write  = e.mem_write;
        m.branch     = e.branch;
`ifdef BNE_EN
        m.branch_ne  = e.branch_ne;
`endif
        m.reg_write  = e.reg_write;
        m.mem_to_reg = e.mem_to_reg;
        return m;
    endfunction

    function automatic wb_ctrl_t to_wb(input mem_ctrl_t m);
        wb_ctrl_t w;
        w.reg_write  = m.reg_write;
        w.mem_to_reg = m.mem_to_reg;
        return w;
    endfunction

    function automatic logic is_legal_func(input logic [FUNC_BITS-1:0] f);
        case (f)
            FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_NOR, FUNC_OR, FUNC_SLT: return 1'b1;
            default:                                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_control_pipe_decoder.sv
// Main decoder: purely combinational opcode/func -> EX control bundle plus illegal flag.
// Ports:
//   opcode_i   instr[31:26]
//   func_i     instr[5:0]
//   ctrl_o     decoded control bundle (bubble when illegal or R-type nop)
//   illegal_o  unsupported opcode or R-type func
// Optional feature macro: BNE_EN decodes bne; without it bne is illegal.
module id_ex_control_pipe_decoder
    import id_ex_control_pipe_pkg::*;
(
    input  logic [OPCODE_BITS-1:0] opcode_i,
    input  logic [FUNC_BITS-1:0]   func_i,
    output ex_ctrl_t               ctrl_o,
    output logic                   illegal_o
);

    // Non-R instructions leave func at the bubble value; the ALU decoder ignores it
    // for aluOp 01/10 but still sees a defined encoding.
    always_comb begin
        ctrl_o    = bubble_ctrl();
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                if (is_legal_func(func_i)) begin
                    ctrl_o.alu_op    = AluOpFunc;
                    ctrl_o.func      = func_i;
                    ctrl_o.reg_dst   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end else if (func_i != FUNC_NOP) begin
                    illegal_o = 1'b1;
                end
            end
            OP_LW: begin
                ctrl_o.alu_op     = AluOpAdd;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alu_op    = AluOpAdd;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.alu_op    = AluOpAdd;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_SLTI: begin
                ctrl_o.alu_op    = AluOpSub;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.alu_op = AluOpSub;
                ctrl_o.branch = 1'b1;
            end
`ifdef BNE_EN
            OP_BNE: begin
                ctrl_o.alu_op    = AluOpSub;
                ctrl_o.branch_ne = 1'b1;
            end
`endif
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_control_pipe.sv
// ID-stage main control plus the ID/EX, EX/MEM and MEM/WB control pipeline registers.
// Per edge the priority is reset > flush > stall > normal advance. Every output is a flop.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_opcode, id_func  instruction fields in ID
//   stall               load-use hazard: bubble into EX, older stages advance
//   flush               taken branch: bubble into EX and MEM, WB advances
//   ex_*                EX-stage controls (ex_illegal is a one-cycle pulse)
//   mem_*               MEM-stage controls
//   wb_*                WB-stage controls
// Optional feature macro: BNE_EN adds bne decode and the mem_branchNe output.
module id_ex_control_pipe
    import id_ex_control_pipe_pkg::*;
#(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned FUNC_W  = 6,
    parameter int unsigned ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_opcode,
    input  logic [FUNC_W-1:0]  id_func,
    input  logic               stall,
    input  logic               flush,
    output logic [ALUOP_W-1:0] ex_aluOp,
    output logic [FUNC_W-1:0]  ex_func,
    output logic               ex_regDst,
    output logic               ex_aluSrc,
    output logic               ex_illegal,
    output logic               mem_memRead,
    output logic               mem_memWrite,
    output logic               mem_branch,
`ifdef BNE_EN
    output logic               mem_branchNe,
`endif
    output logic               wb_regWrite,
    output logic               wb_memToReg
);

    ex_ctrl_t  dec_ctrl;
    logic      dec_illegal;

    ex_ctrl_t  ex_q, ex_d;
    logic      ex_illegal_q, ex_illegal_d;
    mem_ctrl_t mem_q, mem_d;
    wb_ctrl_t  wb_q, wb_d;

    id_ex_control_pipe_decoder u_decoder (
        .opcode_i  (id_opcode),
        .func_i    (id_func),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        ex_d         = bubble_ctrl();
        ex_illegal_d = 1'b0;
        mem_d        = to_mem(ex_q);
        wb_d         = to_wb(mem_q);
        if (flush) begin
            // Kill both the instruction leaving ID and the one leaving EX.
            mem_d = '0;
        end else if (stall) begin
            // EX takes a bubble; ID is held upstream, older stages drain normally.
        end else if (id_valid) begin
            if (dec_illegal) begin
                ex_illegal_d = 1'b1;
            end else begin
                ex_d = dec_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q         <= bubble_ctrl();
            ex_illegal_q <= 1'b0;
            mem_q        <= '0;
            wb_q         <= '0;
        end else begin
            ex_q         <= ex_d;
            ex_illegal_q <= ex_illegal_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
        end
    end

    assign ex_aluOp     = ex_q.alu_op;
    assign ex_func      = ex_q.func;
    assign ex_regDst    = ex_q.reg_dst;
    assign ex_aluSrc    = ex_q.alu_src;
    assign ex_illegal   = ex_illegal_q;
    assign mem_memRead  = mem_q.mem_read;
    assign mem_memWrite = mem_q.mem_write;
    assign mem_branch   = mem_q.branch;
`ifdef BNE_EN
    assign mem_branchNe = mem_q.branch_ne;
`endif
    assign wb_regWrite  = wb_q.reg_write;
    assign wb_memToReg  = wb_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_control_pipe.sv
// Self-checking bench for id_ex_control_pipe: directed sequences, a decode vector table
// and randomized traffic against a three-slot pipeline reference model.
module tb_id_ex_control_pipe;

    logic       clk = 1'b0;
    logic       reset, id_valid, stall, flush;
    logic [5:0] id_opcode, id_func;
    logic [1:0] ex_aluOp;
    logic [5:0] ex_func;
    logic       ex_regDst, ex_aluSrc, ex_illegal;
    logic       mem_memRead, mem_memWrite, mem_branch, mem_branchNe;
    logic       wb_regWrite, wb_memToReg;

    always #5 clk = ~clk;

    id_ex_control_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_func      (id_func),
        .stall        (stall),
        .flush        (flush),
        .ex_aluOp     (ex_aluOp),
        .ex_func      (ex_func),
        .ex_regDst    (ex_regDst),
        .ex_aluSrc    (ex_aluSrc),
        .ex_illegal   (ex_illegal),
        .mem_memRead  (mem_memRead),
        .mem_memWrite (mem_memWrite),
        .mem_branch   (mem_branch),
`ifdef BNE_EN
        .mem_branchNe (mem_branchNe),
`endif
        .wb_regWrite  (wb_regWrite),
        .wb_memToReg  (wb_memToReg)
    );

`ifdef BNE_EN
    localparam bit BNE = 1'b1;
`else
    localparam bit BNE = 1'b0;
    assign mem_branchNe = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] aluop;
        logic [5:0] func;
        logic regdst, alusrc, memread, memwrite, branch, branchne, regwrite, memtoreg, illegal;
    } rec_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [1:0] aluop;
        logic       regdst;
        logic       alusrc;
        logic       illegal;
        string      name;
    } vec_t;

    // Slot 0 = instruction in EX, 1 = in MEM, 2 = in WB.
    rec_t pipe [3];
    int   checks   = 0;
    int   failures = 0;

    function automatic rec_t bubble();
        rec_t r = '0;
        r.func = 6'b100000;
        return r;
    endfunction

    function automatic rec_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
        rec_t r = bubble();
        case (op)
            6'b000000: begin
                if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100111, 6'b100101,
                               6'b101010}) begin
                    r.func = fn; r.regdst = 1; r.regwrite = 1;
                end else if (fn != 6'b000000) begin
                    r.illegal = 1;
                end
            end
            6'b100011: begin
                r.aluop = 2'b01; r.alusrc = 1; r.memread = 1; r.memtoreg = 1; r.regwrite = 1;
            end
            6'b101011: begin r.aluop = 2'b01; r.alusrc = 1; r.memwrite = 1; end
            6'b001000: begin r.aluop = 2'b01; r.alusrc = 1; r.regwrite = 1; end
            6'b001010: begin r.aluop = 2'b10; r.alusrc = 1; r.regwrite = 1; end
            6'b000100: begin r.aluop = 2'b10; r.branch = 1; end
            6'b000101: begin
                if (BNE) begin r.aluop = 2'b10; r.branchne = 1; end
                else r.illegal = 1;
            end
            default: r.illegal = 1;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare every output.
    task automatic step(input logic r, input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic st, input logic fl, input string name);
        logic [16:0] got, exp;
        reset = r; id_valid = v; id_opcode = op; id_func = fn; stall = st; flush = fl;
        @(posedge clk);
        if (r) begin
            pipe[0] = bubble(); pipe[1] = bubble(); pipe[2] = bubble();
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = fl ? bubble() : pipe[0];
            pipe[0] = (fl || st || !v) ? bubble() : ref_decode(op, fn);
        end
        #1;
        got = {ex_aluOp, ex_func, ex_regDst, ex_aluSrc, ex_illegal, mem_memRead, mem_memWrite,
               mem_branch, mem_branchNe, wb_regWrite, wb_memToReg};
        exp = {pipe[0].aluop, pipe[0].func, pipe[0].regdst, pipe[0].alusrc, pipe[0].illegal,
               pipe[1].memread, pipe[1].memwrite, pipe[1].branch, pipe[1].branchne,
               pipe[2].regwrite, pipe[2].memtoreg};
        check(name, 32'(got), 32'(exp));
    endtask

    task automatic idle(input string name);
        step(0, 0, 6'b0, 6'b0, 0, 0, name);
    endtask

    vec_t        vt [$];
    logic [5:0]  ops [8];
    logic [5:0]  fns [7];

    initial begin
        // 1. Reset
        step(1, 0, 6'b0, 6'b0, 0, 0, "t1_reset0");
        step(1, 0, 6'b0, 6'b0, 0, 0, "t1_reset1");
        check("t1_ex_func_reset", 32'(ex_func), 32'h20);
        check("t1_ctrl_zero", 32'({ex_aluOp, ex_regDst, ex_aluSrc, ex_illegal, mem_memRead,
              mem_memWrite, mem_branch, wb_regWrite, wb_memToReg}), 32'h0);
        step(1, 1, 6'b100011, 6'b0, 0, 0, "t1_reset_lw0");
        step(1, 1, 6'b100011, 6'b0, 0, 0, "t1_reset_lw1");
        check("t1_lw_held_off", 32'({ex_aluOp, ex_aluSrc, mem_memRead}), 32'h0);

        // 2. Stream add, lw, sw, beq
        step(0, 1, 6'b000000, 6'b100000, 0, 0, "t2_add");
        check("t2_aluop_add", 32'(ex_aluOp), 32'h0);
        step(0, 1, 6'b100011, 6'b0, 0, 0, "t2_lw");
        check("t2_aluop_lw", 32'(ex_aluOp), 32'h1);
        step(0, 1, 6'b101011, 6'b0, 0, 0, "t2_sw");
        check("t2_aluop_sw", 32'(ex_aluOp), 32'h1);
        check("t2_memtoreg_early", 32'(wb_memToReg), 32'h0);
        step(0, 1, 6'b000100, 6'b0, 0, 0, "t2_beq");
        check("t2_aluop_beq", 32'(ex_aluOp), 32'h2);
        check("t2_lw_wb_memtoreg", 32'(wb_memToReg), 32'h1);
        check("t2_sw_mem_write", 32'(mem_memWrite), 32'h1);
        idle("t2_drain0");
        check("t2_beq_branch", 32'(mem_branch), 32'h1);
        idle("t2_drain1");
        idle("t2_drain2");

        // 3. Load-use stall
        step(0, 1, 6'b100011, 6'b0, 0, 0, "t3_lw");
        step(0, 1, 6'b000000, 6'b100000, 1, 0, "t3_stall");
        check("t3_ex_bubble", 32'({ex_regDst, ex_aluSrc, ex_func}), 32'h20);
        check("t3_lw_memread", 32'(mem_memRead), 32'h1);
        step(0, 1, 6'b000000, 6'b100000, 0, 0, "t3_add_enters");
        check("t3_add_in_ex", 32'(ex_regDst), 32'h1);
        idle("t3_drain0");
        idle("t3_drain1");

        // 4. Flush (with stall) kills EX and MEM
        step(0, 1, 6'b100011, 6'b0, 0, 0, "t4_lw");
        step(0, 1, 6'b001000, 6'b0, 1, 1, "t4_flush");
        check("t4_killed", 32'({mem_memRead, ex_aluSrc, ex_aluOp}), 32'h0);
        idle("t4_after0");
        check("t4_no_writeback", 32'({wb_regWrite, mem_memRead, mem_memWrite}), 32'h0);
        idle("t4_after1");

        // 5. Illegal encodings and nop
        step(0, 1, 6'b111111, 6'b0, 0, 0, "t5_bad_op");
        check("t5_bad_op_pulse", 32'({ex_illegal, ex_aluOp, ex_aluSrc, ex_regDst}), 32'h10);
        step(0, 1, 6'b000000, 6'b000011, 0, 0, "t5_bad_func");
        check("t5_bad_func_pulse", 32'(ex_illegal), 32'h1);
        step(0, 1, 6'b000000, 6'b000000, 0, 0, "t5_nop");
        check("t5_nop_legal", 32'({ex_illegal, ex_regDst}), 32'h0);
        idle("t5_drain");

        // 6. bne
        step(0, 1, 6'b000101, 6'b0, 0, 0, "t6_bne");
`ifdef BNE_EN
        check("t6_bne_aluop", 32'(ex_aluOp), 32'h2);
        idle("t6_drain0");
        check("t6_bne_mem", 32'(mem_branchNe), 32'h1);
`else
        check("t6_bne_illegal", 32'(ex_illegal), 32'h1);
        idle("t6_drain0");
`endif
        idle("t6_drain1");

        // Decode vector table: one instruction per cycle, EX fields checked by hand values
        vt.push_back('{6'b000000, 6'b100000, 2'b00, 1, 0, 0, "v_add"});
        vt.push_back('{6'b000000, 6'b100010, 2'b00, 1, 0, 0, "v_sub"});
        vt.push_back('{6'b000000, 6'b100100, 2'b00, 1, 0, 0, "v_and"});
        vt.push_back('{6'b000000, 6'b100111, 2'b00, 1, 0, 0, "v_nor"});
        vt.push_back('{6'b000000, 6'b100101, 2'b00, 1, 0, 0, "v_or"});
        vt.push_back('{6'b000000, 6'b101010, 2'b00, 1, 0, 0, "v_slt"});
        vt.push_back('{6'b000000, 6'b000000, 2'b00, 0, 0, 0, "v_nop"});
        vt.push_back('{6'b000000, 6'b100001, 2'b00, 0, 0, 1, "v_bad_func"});
        vt.push_back('{6'b100011, 6'b000000, 2'b01, 0, 1, 0, "v_lw"});
        vt.push_back('{6'b101011, 6'b000000, 2'b01, 0, 1, 0, "v_sw"});
        vt.push_back('{6'b001000, 6'b000000, 2'b01, 0, 1, 0, "v_addi"});
        vt.push_back('{6'b001010, 6'b000000, 2'b10, 0, 1, 0, "v_slti"});
        vt.push_back('{6'b000100, 6'b000000, 2'b10, 0, 0, 0, "v_beq"});
        vt.push_back('{6'b000010, 6'b000000, 2'b00, 0, 0, 1, "v_bad_op"});
        vt.push_back('{6'b000101, 6'b000000, BNE ? 2'b10 : 2'b00, 0, 0, !BNE, "v_bne"});
        foreach (vt[i]) begin
            step(0, 1, vt[i].op, vt[i].fn, 0, 0, vt[i].name);
            check({vt[i].name, "_ex"}, 32'({ex_aluOp, ex_regDst, ex_aluSrc, ex_illegal}),
                  32'({vt[i].aluop, vt[i].regdst, vt[i].alusrc, vt[i].illegal}));
        end

        // Randomized traffic against the model
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001010, 6'b000100, 6'b000101,
                6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100111, 6'b100101, 6'b101010, 6'b000000};
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 6'($urandom);
            fn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 6)] : 6'($urandom);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0, op, fn,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
